spi_flash_word_reader: RTL and testbench
========================================

Name: spi_flash_word_reader

Overview:
- Clocked SPI master that fetches 32-bit words from an external serial NOR flash using command 0x03 (READ).
- Used by the management SoC to boot firmware from flash before execution starts.
- Sits between the SoC's simple request/response bus and the flash pins: flash_csb, flash_clk, flash_io0 (MOSI) and flash_io1 (MISO).

Parameters:
- CLK_DIV, 2, number of system clocks per flash_clk half-period; minimum 1.
- WAKE_ON_RESET, 1, when 1, issue a single 0xAB (release power-down) command after reset before accepting requests.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- resetb  in  1  asynchronous, active-low reset.
- req_valid  in  1  read request strobe.
- req_ready  out  1  high when a request is accepted this cycle.
- req_addr  in  24  byte address; bits [1:0] are forced to 0 on the wire.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid while it is high.
- rsp_data  out  32  fetched word, little-endian.
- flash_csb  out  1  flash chip select, active low.
- flash_clk  out  1  SPI clock, mode 0.
- flash_io0  out  1  MOSI.
- flash_io1  in  1  MISO.

Behaviour:
- Reset values while resetb=0 (asynchronous):
  - flash_csb=1, flash_clk=0, flash_io0=0
  - req_ready=0, rsp_valid=0, rsp_data=0
  - state=WAKE if WAKE_ON_RESET=1, else IDLE
- SPI mode 0:
  - flash_clk idles low.
  - flash_io0 changes only while flash_clk is low, at least CLK_DIV clocks before its rising edge.
  - flash_io1 is sampled on the system clock on which flash_clk rises.
  - Each bit takes 2*CLK_DIV system clocks. Bytes are sent MSB first.
- States:
  - WAKE: csb low, shift out 0xAB (8 bits), then csb high → GAP.
  - GAP: csb high for 2*CLK_DIV clocks → IDLE.
  - IDLE: req_ready=1. On req_valid=1, latch {req_addr[23:2],2'b00}, assert csb low on the next clock → CMD.
  - CMD: shift out 0x03 → ADDR.
  - ADDR: shift out the 24 address bits, MSB first → DATA.
  - DATA: sample 32 bits.
    - Byte n (n=0..3, in arrival order) goes to rsp_data[8n+7:8n], each byte MSB first.
    - After the last sample → DONE.
  - DONE: csb high, flash_clk low, rsp_valid=1 for exactly one cycle → GAP.
- req_ready=1 only in IDLE. A request with req_valid=1 outside IDLE is ignored and is not queued.
- Latency:
  - From the accept cycle to the rsp_valid pulse: 1 + 64*2*CLK_DIV + 1 clocks.
  - Minimum gap until the next accept: 2*CLK_DIV clocks.
- rsp_data holds its value until the next DONE.
- Reset asserted mid-transfer:
  - Transfer is abandoned; csb goes high and clk low immediately. No rsp_valid is produced.
  - After release, the wake sequence reruns (if enabled).
- Exactly one flash_clk rising edge per transmitted or sampled bit. No extra edges while csb is low.

Test Plan:
- Reset release, WAKE_ON_RESET=1, CLK_DIV=2 → csb low for 8 clk pulses carrying 0xAB. Then csb high for ≥4 clocks, then req_ready=1.
- Flash bytes at 0x000000 = 6F 00 40 00, request addr 0x000000 → wire shows 0x03,00,00,00. rsp_data=0x0040006F with a single rsp_valid pulse 258 clocks after accept.
- Request addr 0x123457 → wire address bytes 12 34 54 (low bits cleared). The response matches flash bytes at 0x123454..57.
- req_valid held high during a transfer → req_ready=0 and no second transaction starts. The second request is accepted only after GAP; back-to-back responses are correct.
- resetb pulsed low during the DATA phase → flash_csb=1 and flash_clk=0 immediately with no rsp_valid. The wake sequence repeats and the next read is correct.
- CLK_DIV=1 and CLK_DIV=4 → the same data is returned, with latency 130 and 514 clocks respectively.

Source files
------------

// File: rtl/spi_flash_word_reader.sv
// SPI mode-0 master that fetches little-endian 32-bit words from a serial NOR flash
// with the 0x03 READ command, optionally waking the part with 0xAB after reset.
module spi_flash_word_reader #(
  parameter int CLK_DIV       = 2,
  parameter int WAKE_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST     = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE     = CW'(CLK_DIV);

  typedef enum logic [2:0] {WAKE, GAP, IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t        state_reg, state_next;
  logic          lead_reg, lead_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    bit_reg, bit_next;
  logic [31:0]   out_reg, out_next;
  logic [31:0]   in_reg, in_next;
  logic [31:0]   data_reg, data_next;
  logic          csb_reg, csb_next;
  logic          fclk_reg, fclk_next;
  logic          io0_reg, io0_next;
  logic          ready_reg, ready_next;
  logic          valid_reg, valid_next;

  logic [4:0]    phase_last;
  state_t        phase_follow;
  logic          shifting;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      if (WAKE_ON_RESET != 0) state_reg <= WAKE;
      else                    state_reg <= IDLE;
      lead_reg  <= 1'b1;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      out_reg   <= {8'hAB, 24'h000000};
      in_reg    <= '0;
      data_reg  <= '0;
      csb_reg   <= 1'b1;
      fclk_reg  <= 1'b0;
      io0_reg   <= 1'b0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lead_reg  <= lead_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      out_reg   <= out_next;
      in_reg    <= in_next;
      data_reg  <= data_next;
      csb_reg   <= csb_next;
      fclk_reg  <= fclk_next;
      io0_reg   <= io0_next;
      ready_reg <= ready_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lead_next    = lead_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    out_next     = out_reg;
    in_next      = in_reg;
    data_next    = data_reg;
    phase_last   = 5'd31;
    phase_follow = DONE;

    case (state_reg)
      WAKE:    begin phase_last = 5'd7;  phase_follow = GAP;  end
      CMD:     begin phase_last = 5'd7;  phase_follow = ADDR; end
      ADDR:    begin phase_last = 5'd23; phase_follow = DATA; end
      default: begin phase_last = 5'd31; phase_follow = DONE; end
    endcase

    case (state_reg)
      WAKE, CMD, ADDR, DATA: begin
        // The lead cycle gives csb/io0 setup before the first bit's low phase.
        if (lead_reg) begin
          lead_next = 1'b0;
          cnt_next  = '0;
        end else begin
          if (state_reg == DATA && cnt_reg == CNT_PRE_RISE)
            in_next = {in_reg[30:0], flash_io1};
          if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            bit_next = bit_reg + 5'd1;
            out_next = {out_reg[30:0], 1'b0};
            if (bit_reg == phase_last) begin
              bit_next   = '0;
              state_next = phase_follow;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          state_next = CMD;
          lead_next  = 1'b1;
          cnt_next   = '0;
          bit_next   = '0;
          out_next   = {8'h03, req_addr & 24'hFF_FFFC};
        end
      end
      DONE: begin
        state_next = GAP;
        cnt_next   = '0;
      end
      default: state_next = IDLE;
    endcase

    // Pin values are derived from the upcoming state so every output is registered.
    shifting   = state_next inside {WAKE, CMD, ADDR, DATA};
    csb_next   = !shifting;
    fclk_next  = shifting && !lead_next && (cnt_next >= CNT_RISE);
    io0_next   = shifting && (state_next != DATA) && out_next[31];
    ready_next = (state_next == IDLE);
    valid_next = (state_next == DONE);
    if (valid_next)
      data_next = {in_next[7:0], in_next[15:8], in_next[23:16], in_next[31:24]};
  end

  assign req_ready = ready_reg;
  assign rsp_valid = valid_reg;
  assign rsp_data  = data_reg;
  assign flash_csb = csb_reg;
  assign flash_clk = fclk_reg;
  assign flash_io0 = io0_reg;

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Randomized self-checking bench: three readers (CLK_DIV 2, 1, 4), each wired to a
// behavioural serial flash, checked against a word-level model of the flash contents.
module tb_spi_flash_word_reader;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  int total = 0;
  int bad = 0;

  logic        req_valid [3];
  logic [23:0] req_addr  [3];

  logic [2:0]        ready_w, rsp_valid_w, csb_w, fclk_w, io0_w;
  logic [2:0][31:0]  rsp_data_w;
  logic [2:0][7:0]   cmd_w;
  logic [2:0][23:0]  addr_w;
  logic [2:0][31:0]  bits_w;

  always #5 clock = ~clock;

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h6F;
      24'h000001: return 8'h00;
      24'h000002: return 8'h40;
      24'h000003: return 8'h00;
      default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hC3;
    endcase
  endfunction

  // Word returned for a request: aligned base, first-arriving byte in the low lane.
  function automatic logic [31:0] model_word(input logic [23:0] a);
    logic [23:0] base;
    base = a & 24'hFF_FFFC;
    return {flash_byte(base + 24'd3), flash_byte(base + 24'd2),
            flash_byte(base + 24'd1), flash_byte(base)};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic        csb, fclk, io0, rdy, rv;
    logic        io1 = 1'b0;
    logic [31:0] rd;
    logic [31:0] sh = '0;
    int          nbits = 0;
    int          last_bits = 0;
    logic [7:0]  cmd = '0;
    logic [23:0] fa = '0;

    spi_flash_word_reader #(
      .CLK_DIV      (gi == 0 ? 2 : (gi == 1 ? 1 : 4)),
      .WAKE_ON_RESET(1)
    ) u_dut (
      .clock    (clock),
      .resetb   (resetb),
      .req_valid(req_valid[gi]),
      .req_ready(rdy),
      .req_addr (req_addr[gi]),
      .rsp_valid(rv),
      .rsp_data (rd),
      .flash_csb(csb),
      .flash_clk(fclk),
      .flash_io0(io0),
      .flash_io1(io1)
    );

    // Flash side: shift in on rising flash_clk, drive data on falling flash_clk.
    always @(posedge fclk or posedge csb) begin
      if (csb) begin
        last_bits = nbits;
        nbits = 0;
      end else begin
        sh = {sh[30:0], io0};
        nbits++;
        if (nbits == 8)  cmd = sh[7:0];
        if (nbits == 32) fa = sh[23:0];
      end
    end

    always @(negedge fclk) begin
      logic [7:0] b;
      int k;
      if (!csb && nbits >= 32) begin
        k = nbits - 32;
        b = flash_byte(fa + 24'(k / 8));
        io1 = b[7 - (k % 8)];
      end
    end

    assign ready_w[gi]     = rdy;
    assign rsp_valid_w[gi] = rv;
    assign rsp_data_w[gi]  = rd;
    assign csb_w[gi]       = csb;
    assign fclk_w[gi]      = fclk;
    assign io0_w[gi]       = io0;
    assign cmd_w[gi]       = cmd;
    assign addr_w[gi]      = fa;
    assign bits_w[gi]      = 32'(last_bits);
  end

  task automatic test_reset();
    int cyc;
    int rdy_in_wake;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
    end
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      total++; if (csb_w[d] !== 1'b1) begin bad++; $display("FAIL reset_csb[%0d]: got %b want 1", d, csb_w[d]); end
      total++; if (fclk_w[d] !== 1'b0) begin bad++; $display("FAIL reset_clk[%0d]: got %b want 0", d, fclk_w[d]); end
      total++; if (io0_w[d] !== 1'b0) begin bad++; $display("FAIL reset_io0[%0d]: got %b want 0", d, io0_w[d]); end
      total++; if (ready_w[d] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready_w[d]); end
      total++; if (rsp_valid_w[d] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", d, rsp_valid_w[d]); end
      total++; if (rsp_data_w[d] !== 32'h0) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0", d, rsp_data_w[d]); end
    end
    resetb = 1'b1;
    cyc = 0;
    while (csb_w[0] !== 1'b0 && cyc < 100) begin @(negedge clock); cyc++; end
    rdy_in_wake = 0;
    cyc = 0;
    while (csb_w[0] !== 1'b1 && cyc < 500) begin
      if (ready_w[0]) rdy_in_wake++;
      @(negedge clock); cyc++;
    end
    total++; if (cmd_w[0] !== 8'hAB) begin bad++; $display("FAIL wake_cmd: got %h want ab", cmd_w[0]); end
    total++; if (bits_w[0] !== 32'd8) begin bad++; $display("FAIL wake_edges: got %0d want 8", bits_w[0]); end
    total++; if (rdy_in_wake != 0) begin bad++; $display("FAIL wake_ready: got %0d ready cycles want 0", rdy_in_wake); end
    cyc = 0;
    while (!ready_w[0] && cyc < 100) begin @(negedge clock); cyc++; end
    total++;
    if (cyc < 4 || !ready_w[0]) begin bad++; $display("FAIL wake_gap: got %0d csb-high cycles (ready=%b) want >=4 then ready", cyc, ready_w[0]); end
  endtask

  task automatic do_read(input int d, input logic [23:0] a);
    int cyc;
    logic [31:0] expv;
    expv = model_word(a);
    cyc = 0;
    while (!ready_w[d] && cyc < 2000) begin @(negedge clock); cyc++; end
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    @(negedge clock);
    req_valid[d] = 1'b0;
    cyc = 1;
    while (!rsp_valid_w[d] && cyc < 3000) begin @(negedge clock); cyc++; end
    total++;
    if (!rsp_valid_w[d]) begin
      bad++; $display("FAIL read_timeout[%0d]: no rsp_valid for addr %h", d, a);
      return;
    end
    total++; if (rsp_data_w[d] !== expv) begin bad++; $display("FAIL read_data[%0d] addr %h: got %h want %h", d, a, rsp_data_w[d], expv); end
    total++; if (cyc != 1 + 64 * 2 * div_of(d) + 1) begin bad++; $display("FAIL read_latency[%0d]: got %0d want %0d", d, cyc, 1 + 64 * 2 * div_of(d) + 1); end
    total++; if (cmd_w[d] !== 8'h03) begin bad++; $display("FAIL read_cmd[%0d]: got %h want 03", d, cmd_w[d]); end
    total++; if (addr_w[d] !== (a & 24'hFF_FFFC)) begin bad++; $display("FAIL read_wire_addr[%0d]: got %h want %h", d, addr_w[d], a & 24'hFF_FFFC); end
    @(negedge clock);
    total++; if (rsp_valid_w[d] !== 1'b0) begin bad++; $display("FAIL read_pulse[%0d]: rsp_valid still %b", d, rsp_valid_w[d]); end
    total++; if (bits_w[d] !== 32'd64) begin bad++; $display("FAIL read_edges[%0d]: got %0d want 64", d, bits_w[d]); end
    total++; if (rsp_data_w[d] !== expv) begin bad++; $display("FAIL read_hold[%0d]: got %h want %h", d, rsp_data_w[d], expv); end
    $display("read dut=%0d addr=%h data=%h latency=%0d", d, a, rsp_data_w[d], cyc);
  endtask

  task automatic test_directed();
    do_read(0, 24'h000000);
    do_read(0, 24'h123457);
  endtask

  task automatic test_random_reads(input int d, input int n);
    for (int i = 0; i < n; i++) do_read(d, 24'($urandom));
  endtask

  task automatic test_back_to_back(input int d);
    logic [23:0] a1, a2;
    int cyc, ready_seen, gap;
    a1 = 24'($urandom);
    a2 = 24'($urandom);
    cyc = 0;
    while (!ready_w[d] && cyc < 2000) begin @(negedge clock); cyc++; end
    req_valid[d] = 1'b1;
    req_addr[d]  = a1;
    @(negedge clock);
    req_addr[d] = a2;
    cyc = 1;
    ready_seen = 0;
    while (!rsp_valid_w[d] && cyc < 3000) begin
      if (ready_w[d]) ready_seen++;
      @(negedge clock); cyc++;
    end
    total++; if (rsp_data_w[d] !== model_word(a1) || !rsp_valid_w[d]) begin bad++; $display("FAIL b2b_first[%0d]: got %h valid %b want %h", d, rsp_data_w[d], rsp_valid_w[d], model_word(a1)); end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL b2b_busy_ready[%0d]: got %0d ready cycles want 0", d, ready_seen); end
    total++; if (addr_w[d] !== (a1 & 24'hFF_FFFC)) begin bad++; $display("FAIL b2b_first_addr[%0d]: got %h want %h", d, addr_w[d], a1 & 24'hFF_FFFC); end
    gap = 0;
    while (!ready_w[d] && gap < 100) begin @(negedge clock); gap++; end
    total++; if (gap != 2 * div_of(d) + 1) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", d, gap, 2 * div_of(d) + 1); end
    @(negedge clock);
    req_valid[d] = 1'b0;
    cyc = 1;
    while (!rsp_valid_w[d] && cyc < 3000) begin @(negedge clock); cyc++; end
    total++; if (rsp_data_w[d] !== model_word(a2) || !rsp_valid_w[d]) begin bad++; $display("FAIL b2b_second[%0d]: got %h valid %b want %h", d, rsp_data_w[d], rsp_valid_w[d], model_word(a2)); end
    total++; if (cyc != 2 + 128 * div_of(d)) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", d, cyc, 2 + 128 * div_of(d)); end
    $display("b2b dut=%0d a1=%h a2=%h data2=%h gap=%0d", d, a1, a2, rsp_data_w[d], gap);
  endtask

  task automatic test_reset_mid_data();
    logic [23:0] a;
    int cyc, pulses;
    a = 24'($urandom);
    cyc = 0;
    while (!ready_w[0] && cyc < 2000) begin @(negedge clock); cyc++; end
    req_valid[0] = 1'b1;
    req_addr[0]  = a;
    @(negedge clock);
    req_valid[0] = 1'b0;
    pulses = 0;
    repeat (200) begin
      if (rsp_valid_w[0]) pulses++;
      @(negedge clock);
    end
    resetb = 1'b0;
    #1;
    total++; if (csb_w[0] !== 1'b1) begin bad++; $display("FAIL abort_csb: got %b want 1", csb_w[0]); end
    total++; if (fclk_w[0] !== 1'b0) begin bad++; $display("FAIL abort_clk: got %b want 0", fclk_w[0]); end
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    cyc = 0;
    while (csb_w[0] !== 1'b0 && cyc < 100) begin
      if (rsp_valid_w[0]) pulses++;
      @(negedge clock); cyc++;
    end
    cyc = 0;
    while (csb_w[0] !== 1'b1 && cyc < 500) begin
      if (rsp_valid_w[0]) pulses++;
      @(negedge clock); cyc++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_rsp: got %0d rsp_valid pulses want 0", pulses); end
    total++; if (cmd_w[0] !== 8'hAB || bits_w[0] !== 32'd8) begin bad++; $display("FAIL abort_rewake: got cmd %h edges %0d want ab/8", cmd_w[0], bits_w[0]); end
    $display("abort dut=0 addr=%h rewake_cmd=%h", a, cmd_w[0]);
    do_read(0, 24'($urandom));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_reads(0, 4);
    test_back_to_back(0);
    test_back_to_back(1);
    do_read(1, 24'h000000);
    do_read(2, 24'h000000);
    test_random_reads(1, 2);
    test_random_reads(2, 2);
    test_back_to_back(2);
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
